// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup, EX-update and perf-counter signals of the branch target buffer.
// The master side is the core pipeline; the slave side is the BTB itself.
interface branch_predictor_btb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next_pc;
  logic            upd_en;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;
  logic            flush_all;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    input  pred_hit, pred_taken, pred_next_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    output pred_hit, pred_taken, pred_next_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry, zero-latency lookup,
// registered training from EX, and branch / mispredict performance counters.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32,
  parameter int CNT_SAT = 1
) (
  input  logic clk,
  input  logic reset,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [31:0]        branch_q, branch_d;
  logic [31:0]        mispred_q, mispred_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             unused_lo;

  assign lk_idx    = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag    = bus.lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx    = bus.upd_pc[IDX_W+1:2];
  assign up_tag    = bus.upd_pc[XLEN-1:IDX_W+2];
  assign unused_lo = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // Lookup reads only registered state, so a same-cycle update is never visible.
  always_comb begin
    bus.pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.pred_taken   = bus.pred_hit && ctr_q[lk_idx][1];
    bus.pred_next_pc = bus.pred_taken ? tgt_q[lk_idx] : (bus.lookup_pc + XLEN'(4));
  end

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (bus.upd_en) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
          tgt_d[up_idx] = bus.upd_target;
        end else begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = bus.upd_target;
        ctr_d[up_idx]   = 2'd2;
      end
    end
    if (bus.flush_all) valid_d = '0;
  end

  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (bus.upd_en) begin
      branch_d = ((CNT_SAT != 0) && (&branch_q)) ? branch_q : branch_q + 32'd1;
      if (bus.upd_mispredict)
        mispred_d = ((CNT_SAT != 0) && (&mispred_q)) ? mispred_q : mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      ctr_q     <= ctr_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

  assign bus.branch_cnt  = branch_q;
  assign bus.mispred_cnt = mispred_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: lookup, training, aliasing, flush, reset and
// perf-counter saturate/wrap behaviour with hand-computed expectations.
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic reset;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor_btb_if #(.XLEN(32)) bus ();
  branch_predictor_btb_if #(.XLEN(32)) bw ();

  branch_predictor_btb #(.ENTRIES(16), .XLEN(32), .CNT_SAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  branch_predictor_btb #(.ENTRIES(16), .XLEN(32), .CNT_SAT(0)) dut_w (
    .clk(clk), .reset(reset), .bus(bw)
  );

  assign bw.lookup_pc      = bus.lookup_pc;
  assign bw.upd_en         = bus.upd_en;
  assign bw.upd_pc         = bus.upd_pc;
  assign bw.upd_taken      = bus.upd_taken;
  assign bw.upd_target     = bus.upd_target;
  assign bw.upd_mispredict = bus.upd_mispredict;
  assign bw.flush_all      = bus.flush_all;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.upd_en         = 1'b0;
    bus.upd_mispredict = 1'b0;
    bus.flush_all      = 1'b0;
    reset              = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic mis);
    bus.upd_en         = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = taken;
    bus.upd_target     = tgt;
    bus.upd_mispredict = mis;
    tick();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] npc);
    bus.lookup_pc = pc;
    #1;
    expect_eq({tag, ".hit"},   {31'd0, bus.pred_hit},   {31'd0, hit});
    expect_eq({tag, ".taken"}, {31'd0, bus.pred_taken}, {31'd0, taken});
    expect_eq({tag, ".npc"},   bus.pred_next_pc,        npc);
  endtask

  initial begin
    reset              = 1'b1;
    bus.lookup_pc      = '0;
    bus.upd_en         = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;
    bus.upd_mispredict = 1'b0;
    bus.flush_all      = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    expect_eq("rst.bcnt", bus.branch_cnt, 32'd0);
    expect_eq("rst.mcnt", bus.mispred_cnt, 32'd0);

    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    expect_eq("alloc.bcnt", bus.branch_cnt, 32'd1);
    expect_eq("alloc.mcnt", bus.mispred_cnt, 32'd1);

    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("nt1", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
    expect_eq("nt2.bcnt", bus.branch_cnt, 32'd5);

    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    look("floor", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    look("retgt", 32'h40, 1'b1, 1'b1, 32'h200);

    upd(32'h44, 1'b0, 32'h600, 1'b0);
    look("missnt", 32'h44, 1'b0, 1'b0, 32'h48);

    upd(32'h8000_0040, 1'b1, 32'h300, 1'b0);
    look("alias.u", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias.k", 32'h8000_0040, 1'b1, 1'b1, 32'h300);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    bus.upd_en     = 1'b1;
    bus.upd_pc     = 32'h48;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h500;
    look("nobyp", 32'h48, 1'b0, 1'b0, 32'h4C);
    tick();
    look("postupd", 32'h48, 1'b1, 1'b1, 32'h500);
    expect_eq("pre.bcnt", bus.branch_cnt, 32'd12);

    bus.flush_all = 1'b1;
    upd(32'h40, 1'b1, 32'h700, 1'b1);
    look("fl.k", 32'h8000_0040, 1'b0, 1'b0, 32'h8000_0044);
    look("fl.48", 32'h48, 1'b0, 1'b0, 32'h4C);
    look("fl.40", 32'h40, 1'b0, 1'b0, 32'h44);
    expect_eq("fl.bcnt", bus.branch_cnt, 32'd13);
    expect_eq("fl.mcnt", bus.mispred_cnt, 32'd2);

    upd(32'h40, 1'b1, 32'h100, 1'b1);
    reset = 1'b1;
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("midrst", 32'h40, 1'b0, 1'b0, 32'h44);
    expect_eq("midrst.bcnt", bus.branch_cnt, 32'd0);
    expect_eq("midrst.mcnt", bus.mispred_cnt, 32'd0);

    // Preloading all-ones by counting would take 2^32 updates, so the register is forced.
    force dut.mispred_q   = 32'hFFFF_FFFF;
    force dut_w.mispred_q = 32'hFFFF_FFFF;
    bus.upd_en         = 1'b1;
    bus.upd_mispredict = 1'b1;
    #1;
    expect_eq("sat.next",  dut.mispred_d,   32'hFFFF_FFFF);
    expect_eq("wrap.next", dut_w.mispred_d, 32'h0);
    bus.upd_en         = 1'b0;
    bus.upd_mispredict = 1'b0;
    release dut.mispred_q;
    release dut_w.mispred_q;
    reset = 1'b1;
    tick();
    expect_eq("end.mcnt", bus.mispred_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
